// File: rtl/stream_demux1x2.sv
// -----------------------------------------------------------------------------
// stream_demux1x2
//
// Routes one valid/ready packet stream to one of two outputs. The channel is
// taken from `sel` on the first beat of a packet and held until the packet's
// last beat. Each output has its own FIFO, so a stalled consumer on one
// channel does not block traffic to the other.
//
// Parameters:
//   WIDTH  payload width of each beat
//   DEPTH  entries per output FIFO (power of 2, >= 2)
//
// Ports:
//   clk, rst_n                       clock, asynchronous active-low reset
//   in_valid/in_ready/in_data/in_last input stream
//   sel                              destination channel (first beat only)
//   outN_valid/outN_ready/outN_data/outN_last  output streams, N = 0, 1
//   busy                             a packet is open
//   locked_sel                       channel latched for the open packet
// -----------------------------------------------------------------------------
module stream_demux1x2 #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_last,
   input  logic             sel,
   output logic             out0_valid,
   input  logic             out0_ready,
   output logic [WIDTH-1:0] out0_data,
   output logic             out0_last,
   output logic             out1_valid,
   input  logic             out1_ready,
   output logic [WIDTH-1:0] out1_data,
   output logic             out1_last,
   output logic             busy,
   output logic             locked_sel
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = $clog2(DEPTH + 1);

   typedef enum logic {
      IDLE = 1'b0,
      PKT  = 1'b1
   } state_e;

   state_e         state_q, state_d;
   logic           locked_q, locked_d;
   logic           route;
   logic           accept;
   logic [1:0]     full;
   logic [1:0]     empty;
   logic [1:0]     push;
   logic [1:0]     pop;
   logic [1:0]     out_ready;
   logic [WIDTH:0] head [2];

   // Inside a packet the latched channel wins; between packets `sel` steers
   // directly so the first beat needs no extra cycle.
   assign route     = (state_q == PKT) ? locked_q : sel;
   // Readiness comes only from registered counts, so a full FIFO cannot take
   // a push in the same cycle it pops.
   assign in_ready  = rst_n & ~full[route];
   assign accept    = in_valid & in_ready;
   assign push[0]   = accept & ~route;
   assign push[1]   = accept &  route;
   assign out_ready = {out1_ready, out0_ready};

   always_comb begin
      state_d  = state_q;
      locked_d = locked_q;
      case (state_q)
         IDLE: begin
            // Single-beat packets leave the FSM and the latched channel alone.
            if (accept && !in_last) begin
               state_d  = PKT;
               locked_d = sel;
            end
         end
         PKT: begin
            if (accept && in_last) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         locked_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         locked_q <= locked_d;
      end
   end

   for (genvar ch = 0; ch < 2; ch++) begin : g_fifo
      logic [WIDTH:0]   mem_q [DEPTH];
      logic [PTR_W-1:0] wr_q, wr_d;
      logic [PTR_W-1:0] rd_q, rd_d;
      logic [CNT_W-1:0] cnt_q, cnt_d;

      assign full[ch]  = (cnt_q == CNT_W'(DEPTH));
      assign empty[ch] = (cnt_q == '0);
      assign pop[ch]   = ~empty[ch] & out_ready[ch];
      // Outputs read zero while empty; no bypass of the incoming beat.
      assign head[ch]  = empty[ch] ? '0 : mem_q[rd_q];

      always_comb begin
         wr_d  = wr_q;
         rd_d  = rd_q;
         cnt_d = cnt_q;
         // DEPTH is a power of 2, so pointers wrap by natural overflow.
         if (push[ch]) wr_d = wr_q + PTR_W'(1);
         if (pop[ch])  rd_d = rd_q + PTR_W'(1);
         case ({push[ch], pop[ch]})
            2'b10:   cnt_d = cnt_q + CNT_W'(1);
            2'b01:   cnt_d = cnt_q - CNT_W'(1);
            default: cnt_d = cnt_q;
         endcase
      end

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
         end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
         end
      end

      // Storage needs no reset: entries are only visible through cnt_q.
      always_ff @(posedge clk) begin
         if (push[ch]) begin
            mem_q[wr_q] <= {in_last, in_data};
         end
      end
   end

   assign out0_valid = ~empty[0];
   assign out0_data  = head[0][WIDTH-1:0];
   assign out0_last  = head[0][WIDTH];
   assign out1_valid = ~empty[1];
   assign out1_data  = head[1][WIDTH-1:0];
   assign out1_last  = head[1][WIDTH];

   assign busy       = (state_q == PKT);
   assign locked_sel = locked_q;

endmodule

// File: tb/tb_stream_demux1x2.sv
module tb_stream_demux1x2;

   localparam int WIDTH = 8;
   localparam int DEPTH = 2;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             in_valid = 1'b0;
   logic             in_ready;
   logic [WIDTH-1:0] in_data = '0;
   logic             in_last = 1'b0;
   logic             sel = 1'b0;
   logic             out0_valid, out1_valid;
   logic             out0_ready = 1'b0, out1_ready = 1'b0;
   logic [WIDTH-1:0] out0_data, out1_data;
   logic             out0_last, out1_last;
   logic             busy, locked_sel;

   stream_demux1x2 #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_data    (in_data),
      .in_last    (in_last),
      .sel        (sel),
      .out0_valid (out0_valid),
      .out0_ready (out0_ready),
      .out0_data  (out0_data),
      .out0_last  (out0_last),
      .out1_valid (out1_valid),
      .out1_ready (out1_ready),
      .out1_data  (out1_data),
      .out1_last  (out1_last),
      .busy       (busy),
      .locked_sel (locked_sel)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural reference: two queues + open/locked flags
   logic [WIDTH:0] mq0[$];
   logic [WIDTH:0] mq1[$];
   logic           m_open = 1'b0;
   logic           m_lock = 1'b0;
   logic           last_acc = 1'b0;
   logic           dut_rdy_seen = 1'b0;
   logic           dut_v1_seen = 1'b0;
   logic [WIDTH-1:0] dut_d1_seen = '0;

   function automatic int msize(input logic ch);
      return ch ? mq1.size() : mq0.size();
   endfunction

   // Inputs are driven 1 time unit after a rising edge; this settles, compares
   // every output with the model, then advances both across one edge.
   task automatic cycle();
      logic route, rdy, acc, p0, p1, l_in, s_in;
      logic [WIDTH-1:0] d_in;
      logic [WIDTH:0] h0, h1;
      #1;
      if (!rst_n) begin
         mq0.delete();
         mq1.delete();
         m_open = 1'b0;
         m_lock = 1'b0;
      end
      route = m_open ? m_lock : sel;
      rdy   = rst_n && (msize(route) < DEPTH);
      h0    = (mq0.size() != 0) ? mq0[0] : '0;
      h1    = (mq1.size() != 0) ? mq1[0] : '0;
      chk("in_ready",   in_ready,   rdy);
      chk("out0_valid", out0_valid, mq0.size() != 0);
      chk("out0_data",  out0_data,  h0[WIDTH-1:0]);
      chk("out0_last",  out0_last,  h0[WIDTH]);
      chk("out1_valid", out1_valid, mq1.size() != 0);
      chk("out1_data",  out1_data,  h1[WIDTH-1:0]);
      chk("out1_last",  out1_last,  h1[WIDTH]);
      chk("busy",       busy,       m_open);
      chk("locked_sel", locked_sel, m_lock);
      dut_rdy_seen = in_ready;
      dut_v1_seen  = out1_valid;
      dut_d1_seen  = out1_data;
      acc  = in_valid && rdy;
      p0   = (mq0.size() != 0) && out0_ready;
      p1   = (mq1.size() != 0) && out1_ready;
      l_in = in_last;
      s_in = sel;
      d_in = in_data;
      last_acc = acc;
      @(posedge clk);
      if (rst_n) begin
         if (p0) void'(mq0.pop_front());
         if (p1) void'(mq1.pop_front());
         if (acc) begin
            if (route) mq1.push_back({l_in, d_in});
            else       mq0.push_back({l_in, d_in});
            if (!m_open && !l_in) begin
               m_open = 1'b1;
               m_lock = s_in;
            end else if (m_open && l_in) begin
               m_open = 1'b0;
            end
         end
      end
      #1;
   endtask

   task automatic send(input logic [WIDTH-1:0] d, input logic l, input logic s);
      in_valid = 1'b1;
      in_data  = d;
      in_last  = l;
      sel      = s;
      for (int n = 0; n < 50; n++) begin
         cycle();
         if (last_acc) break;
      end
      if (!last_acc) begin
         checks++;
         failures++;
         $display("FAIL send_timeout: beat 0x%0h not accepted within 50 cycles", d);
      end
      in_valid = 1'b0;
   endtask

   // ---------------- directed vector table (single beats + packet lock)
   typedef struct {
      logic             v;
      logic [WIDTH-1:0] d;
      logic             l;
      logic             s;
      logic             r0;
      logic             r1;
      logic             e_rdy;
      logic             e_v0;
      logic [WIDTH-1:0] e_d0;
      logic             e_l0;
      logic             e_v1;
      logic [WIDTH-1:0] e_d1;
      logic             e_l1;
      logic             e_busy;
      logic             e_lock;
   } vec_t;

   vec_t tbl [10];

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      //           v  d      l  s  r0 r1  rdy v0 d0     l0 v1 d1     l1 busy lock
      tbl[0] = '{1, 8'h11, 1, 0, 0, 0,  1,  0, 8'h00, 0, 0, 8'h00, 0, 0,   0};
      tbl[1] = '{1, 8'h22, 1, 1, 0, 0,  1,  1, 8'h11, 1, 0, 8'h00, 0, 0,   0};
      tbl[2] = '{1, 8'hA0, 0, 1, 1, 0,  1,  1, 8'h11, 1, 1, 8'h22, 1, 0,   0};
      tbl[3] = '{1, 8'hA1, 0, 0, 0, 0,  0,  0, 8'h00, 0, 1, 8'h22, 1, 1,   1};
      tbl[4] = '{1, 8'hA1, 0, 0, 0, 1,  0,  0, 8'h00, 0, 1, 8'h22, 1, 1,   1};
      tbl[5] = '{1, 8'hA1, 0, 0, 0, 0,  1,  0, 8'h00, 0, 1, 8'hA0, 0, 1,   1};
      tbl[6] = '{1, 8'hA2, 1, 0, 0, 1,  0,  0, 8'h00, 0, 1, 8'hA0, 0, 1,   1};
      tbl[7] = '{1, 8'hA2, 1, 0, 0, 1,  1,  0, 8'h00, 0, 1, 8'hA1, 0, 1,   1};
      tbl[8] = '{0, 8'h00, 0, 0, 0, 1,  1,  0, 8'h00, 0, 1, 8'hA2, 1, 0,   1};
      tbl[9] = '{0, 8'h00, 0, 0, 0, 0,  1,  0, 8'h00, 0, 0, 8'h00, 0, 0,   1};

      // Reset state
      rst_n = 1'b0;
      #2;
      cycle();
      cycle();
      rst_n = 1'b1;

      for (int i = 0; i < 10; i++) begin
         in_valid   = tbl[i].v;
         in_data    = tbl[i].d;
         in_last    = tbl[i].l;
         sel        = tbl[i].s;
         out0_ready = tbl[i].r0;
         out1_ready = tbl[i].r1;
         #1;
         chk($sformatf("tbl%0d_in_ready", i),   in_ready,   tbl[i].e_rdy);
         chk($sformatf("tbl%0d_out0_valid", i), out0_valid, tbl[i].e_v0);
         chk($sformatf("tbl%0d_out0_data", i),  out0_data,  tbl[i].e_d0);
         chk($sformatf("tbl%0d_out0_last", i),  out0_last,  tbl[i].e_l0);
         chk($sformatf("tbl%0d_out1_valid", i), out1_valid, tbl[i].e_v1);
         chk($sformatf("tbl%0d_out1_data", i),  out1_data,  tbl[i].e_d1);
         chk($sformatf("tbl%0d_out1_last", i),  out1_last,  tbl[i].e_l1);
         chk($sformatf("tbl%0d_busy", i),       busy,       tbl[i].e_busy);
         chk($sformatf("tbl%0d_locked_sel", i), locked_sel, tbl[i].e_lock);
         @(posedge clk);
         #1;
      end
      in_valid   = 1'b0;
      out0_ready = 1'b0;
      out1_ready = 1'b0;

      // Re-reset so the reference model starts in step with the DUT
      rst_n = 1'b0;
      cycle();
      rst_n = 1'b1;
      cycle();

      // Backpressure / full on channel 0
      send(8'h00, 1'b1, 1'b0);
      send(8'h01, 1'b1, 1'b0);
      in_valid = 1'b1; in_data = 8'h02; in_last = 1'b1; sel = 1'b0;
      cycle();
      chk("bp_full_ready", dut_rdy_seen, 1'b0);
      out0_ready = 1'b1;
      cycle();
      chk("bp_pop_cycle_ready", dut_rdy_seen, 1'b0);
      chk("bp_pop_cycle_acc", last_acc, 1'b0);
      out0_ready = 1'b0;
      cycle();
      chk("bp_after_pop_ready", dut_rdy_seen, 1'b1);
      chk("bp_head_after_pop", out0_data, 8'h01);
      in_valid = 1'b0;

      // Head-of-line independence: channel 0 full and stalled
      in_valid = 1'b1; in_data = 8'h77; in_last = 1'b1; sel = 1'b1;
      cycle();
      chk("hol_ready", dut_rdy_seen, 1'b1);
      chk("hol_acc", last_acc, 1'b1);
      in_valid = 1'b0;
      cycle();
      chk("hol_out1_data", dut_d1_seen, 8'h77);
      chk("hol_out0_still_full", out0_valid, 1'b1);

      // Drain, then the fourth channel-0 beat
      out0_ready = 1'b1;
      out1_ready = 1'b1;
      send(8'h03, 1'b1, 1'b0);
      for (int n = 0; n < 4; n++) cycle();
      chk("bp_drained", out0_valid, 1'b0);

      // Simultaneous push/pop on channel 1, one 8-beat packet
      for (int k = 0; k < 8; k++) begin
         in_valid = 1'b1; in_data = WIDTH'(k); in_last = (k == 7); sel = (k == 0);
         cycle();
         chk($sformatf("ss_ready%0d", k), dut_rdy_seen, 1'b1);
         if (k > 0) begin
            chk($sformatf("ss_v1_%0d", k), dut_v1_seen, 1'b1);
            chk($sformatf("ss_d1_%0d", k), dut_d1_seen, WIDTH'(k - 1));
         end
      end
      in_valid = 1'b0;
      cycle();
      chk("ss_final_data", dut_d1_seen, 8'h07);
      cycle();

      // Reset mid-packet with data queued
      out0_ready = 1'b0;
      out1_ready = 1'b0;
      send(8'h30, 1'b0, 1'b0);
      send(8'h31, 1'b0, 1'b0);
      chk("rst_pre_busy", busy, 1'b1);
      in_valid = 1'b1; in_data = 8'h32; in_last = 1'b0;
      rst_n = 1'b0;
      #1;
      chk("rst_out0_valid", out0_valid, 1'b0);
      chk("rst_out1_valid", out1_valid, 1'b0);
      chk("rst_busy", busy, 1'b0);
      chk("rst_in_ready", in_ready, 1'b0);
      chk("rst_out0_data", out0_data, 8'h00);
      in_valid = 1'b0;
      cycle();
      rst_n = 1'b1;
      send(8'h55, 1'b1, 1'b1);
      cycle();
      chk("post_rst_out1", dut_d1_seen, 8'h55);
      chk("post_rst_out0_valid", out0_valid, 1'b0);
      out1_ready = 1'b1;
      cycle();
      cycle();

      // Randomized traffic against the reference model
      in_valid = 1'b0;
      last_acc = 1'b0;
      for (int i = 0; i < 3000; i++) begin
         if (!(in_valid && !last_acc)) begin
            in_valid = ($urandom_range(0, 3) != 0);
            in_data  = WIDTH'($urandom);
            in_last  = ($urandom_range(0, 3) == 0);
            sel      = 1'($urandom);
         end
         out0_ready = ($urandom_range(0, 2) != 0);
         out1_ready = ($urandom_range(0, 3) == 0);
         cycle();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
